// File: rtl/rf_arb_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package rf_arb_pkg;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FORCE = 2'd2
  } arb_state_t;

  localparam int REG_ADDR_W = 5;
  localparam int REG_COUNT  = 32;

endpackage

// File: rtl/rf_clear_counter.sv
// Address sweep counter used to zero the register file after reset.
module rf_clear_counter
  import rf_arb_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  output logic [REG_ADDR_W-1:0] cnt,
  output logic                  done
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + REG_ADDR_W'(1);
    end
  end

  assign done = (cnt == REG_ADDR_W'(REG_COUNT - 1));

endmodule

// File: rtl/rf_write_arbiter.sv
// Owns the register-file write port; shares it between the reset clear sweep,
// pipeline write-back and an auxiliary requester with bounded aux starvation.
module rf_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int MAX_WAIT       = 4,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_we,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [XLEN-1:0]       wb_data,
  input  logic                  aux_valid,
  output logic                  aux_ready,
  input  logic [REG_ADDR_W-1:0] aux_rd,
  input  logic [XLEN-1:0]       aux_data,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_a3,
  output logic [XLEN-1:0]       rf_wd3,
  output logic                  pipe_stall,
  output logic                  init_busy
);

  localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
  localparam arb_state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_INIT : ST_RUN;

  arb_state_t            state, state_nxt;
  logic [WAIT_W-1:0]     wait_cnt, wait_nxt;
  logic [REG_ADDR_W-1:0] clr_cnt;
  logic                  clr_done;
  logic                  clr_en;
  logic                  wb_req;

  rf_clear_counter u_clear (
    .clk  (clk),
    .rst  (rst),
    .en   (clr_en),
    .cnt  (clr_cnt),
    .done (clr_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RESET_STATE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  // Writes to x0 are dropped by WB, so they leave the slot free for aux.
  assign wb_req = wb_we && (wb_rd != '0);

  always_comb begin
    state_nxt  = state;
    wait_nxt   = wait_cnt;
    clr_en     = 1'b0;
    rf_we      = 1'b0;
    rf_a3      = '0;
    rf_wd3     = '0;
    aux_ready  = 1'b0;
    pipe_stall = 1'b0;
    init_busy  = 1'b0;

    case (state)
      ST_INIT: begin
        clr_en     = 1'b1;
        rf_we      = 1'b1;
        rf_a3      = clr_cnt;
        pipe_stall = 1'b1;
        init_busy  = 1'b1;
        if (clr_done) state_nxt = ST_RUN;
      end

      ST_RUN: begin
        if (wb_req) begin
          rf_we  = 1'b1;
          rf_a3  = wb_rd;
          rf_wd3 = wb_data;
          if (aux_valid) begin
            if (wait_cnt != WAIT_MAX) wait_nxt = wait_cnt + WAIT_W'(1);
            if (wait_cnt == WAIT_LAST) state_nxt = ST_FORCE;
          end else begin
            wait_nxt = '0;
          end
        end else if (aux_valid) begin
          aux_ready = 1'b1;
          rf_we     = (aux_rd != '0);
          rf_a3     = aux_rd;
          rf_wd3    = aux_data;
          wait_nxt  = '0;
        end else begin
          wait_nxt = '0;
        end
      end

      ST_FORCE: begin
        pipe_stall = 1'b1;
        aux_ready  = 1'b1;
        wait_nxt   = '0;
        state_nxt  = ST_RUN;
        if (aux_valid) begin
          rf_we  = (aux_rd != '0);
          rf_a3  = aux_rd;
          rf_wd3 = aux_data;
        end
      end

      default: begin
        state_nxt = ST_RUN;
        wait_nxt  = '0;
      end
    endcase

    if (rst) begin
      rf_we      = 1'b0;
      rf_a3      = '0;
      rf_wd3     = '0;
      aux_ready  = 1'b0;
      pipe_stall = 1'b1;
      init_busy  = (CLEAR_ON_RESET != 0);
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: clear sweep, WB/aux arbitration, forced
// aux slot, x0 handling, reset mid-sweep and the no-clear configuration.
module tb_rf_write_arbiter;

  logic        clk = 1'b0;
  logic        rst, rst0;
  logic        wb_we, aux_valid;
  logic [4:0]  wb_rd, aux_rd;
  logic [31:0] wb_data, aux_data;
  logic        aux_ready, rf_we, pipe_stall, init_busy;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wd3;

  logic        wb_we0;
  logic [4:0]  wb_rd0;
  logic [31:0] wb_data0;
  logic        aux_ready0, rf_we0, pipe_stall0, init_busy0;
  logic [4:0]  rf_a30;
  logic [31:0] rf_wd30;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rf_write_arbiter #(.XLEN(32), .MAX_WAIT(4), .CLEAR_ON_RESET(1)) dut (
    .clk(clk), .rst(rst),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .aux_valid(aux_valid), .aux_ready(aux_ready), .aux_rd(aux_rd), .aux_data(aux_data),
    .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd3(rf_wd3),
    .pipe_stall(pipe_stall), .init_busy(init_busy)
  );

  rf_write_arbiter #(.XLEN(32), .MAX_WAIT(4), .CLEAR_ON_RESET(0)) dut0 (
    .clk(clk), .rst(rst0),
    .wb_we(wb_we0), .wb_rd(wb_rd0), .wb_data(wb_data0),
    .aux_valid(1'b0), .aux_ready(aux_ready0), .aux_rd(5'd0), .aux_data(32'd0),
    .rf_we(rf_we0), .rf_a3(rf_a30), .rf_wd3(rf_wd30),
    .pipe_stall(pipe_stall0), .init_busy(init_busy0)
  );

  // Packed view: {rf_we, rf_a3, rf_wd3, aux_ready, pipe_stall, init_busy}
  function automatic logic [40:0] pk(logic we, logic [4:0] a3, logic [31:0] wd,
                                     logic rdy, logic stl, logic bsy);
    return {we, a3, wd, rdy, stl, bsy};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wb_we = 1'b0; wb_rd = '0; wb_data = '0;
    aux_valid = 1'b0; aux_rd = '0; aux_data = '0;
  endtask

  task automatic test_reset();
    logic [40:0] obs, exp;
    tick();
    @(negedge clk);
    n_cmp++;
    obs = pk(rf_we, rf_a3, rf_wd3, aux_ready, pipe_stall, init_busy);
    exp = pk(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b1);
    if (obs !== exp) begin
      n_err++; $display("FAIL reset_hold got=%h exp=%h", obs, exp);
    end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      n_cmp++;
      obs = pk(rf_we, rf_a3, rf_wd3, aux_ready, pipe_stall, init_busy);
      exp = pk(1'b1, 5'(i), 32'd0, 1'b0, 1'b1, 1'b1);
      if (obs !== exp) begin
        n_err++; $display("FAIL clear_sweep[%0d] got=%h exp=%h", i, obs, exp);
      end
      tick();
    end
    @(negedge clk);
    n_cmp++;
    obs = pk(rf_we, rf_a3, rf_wd3, aux_ready, pipe_stall, init_busy);
    exp = pk(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    if (obs !== exp) begin
      n_err++; $display("FAIL run_after_clear got=%h exp=%h", obs, exp);
    end
    tick();
  endtask

  task automatic test_wb_priority();
    logic [40:0] obs, exp;
    wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF;
    aux_valid = 1'b1; aux_rd = 5'd6; aux_data = 32'h12345678;
    @(negedge clk);
    n_cmp++;
    obs = pk(rf_we, rf_a3, rf_wd3, aux_ready, pipe_stall, init_busy);
    exp = pk(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
    if (obs !== exp) begin
      n_err++; $display("FAIL wb_wins got=%h exp=%h", obs, exp);
    end
    tick();
    wb_we = 1'b0;
    @(negedge clk);
    n_cmp++;
    obs = pk(rf_we, rf_a3, rf_wd3, aux_ready, pipe_stall, init_busy);
    exp = pk(1'b1, 5'd6, 32'h12345678, 1'b1, 1'b0, 1'b0);
    if (obs !== exp) begin
      n_err++; $display("FAIL aux_after_wb got=%h exp=%h", obs, exp);
    end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_force();
    logic [40:0] obs, exp;
    aux_valid = 1'b1; aux_rd = 5'd7; aux_data = 32'h0000A5A5;
    wb_we = 1'b1; wb_rd = 5'd1;
    for (int k = 0; k < 4; k++) begin
      wb_data = 32'h100 + 32'(k);
      @(negedge clk);
      n_cmp++;
      obs = pk(rf_we, rf_a3, rf_wd3, aux_ready, pipe_stall, init_busy);
      exp = pk(1'b1, 5'd1, 32'h100 + 32'(k), 1'b0, 1'b0, 1'b0);
      if (obs !== exp) begin
        n_err++; $display("FAIL force_wb_cycle[%0d] got=%h exp=%h", k, obs, exp);
      end
      tick();
    end
    wb_data = 32'h200;
    @(negedge clk);
    n_cmp++;
    obs = pk(rf_we, rf_a3, rf_wd3, aux_ready, pipe_stall, init_busy);
    exp = pk(1'b1, 5'd7, 32'h0000A5A5, 1'b1, 1'b1, 1'b0);
    if (obs !== exp) begin
      n_err++; $display("FAIL force_slot got=%h exp=%h", obs, exp);
    end
    tick();
    aux_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    obs = pk(rf_we, rf_a3, rf_wd3, aux_ready, pipe_stall, init_busy);
    exp = pk(1'b1, 5'd1, 32'h200, 1'b0, 1'b0, 1'b0);
    if (obs !== exp) begin
      n_err++; $display("FAIL wb_resume got=%h exp=%h", obs, exp);
    end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_x0();
    logic [40:0] obs, exp;
    wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFF0000;
    aux_valid = 1'b1; aux_rd = 5'd9; aux_data = 32'h99;
    @(negedge clk);
    n_cmp++;
    obs = pk(rf_we, rf_a3, rf_wd3, aux_ready, pipe_stall, init_busy);
    exp = pk(1'b1, 5'd9, 32'h99, 1'b1, 1'b0, 1'b0);
    if (obs !== exp) begin
      n_err++; $display("FAIL wb_x0_frees_slot got=%h exp=%h", obs, exp);
    end
    tick();
    wb_we = 1'b0; aux_rd = 5'd0; aux_data = 32'h55;
    @(negedge clk);
    n_cmp++;
    obs = {rf_we, aux_ready, pipe_stall};
    exp = {38'd0, 3'b010};
    if (obs !== exp) begin
      n_err++; $display("FAIL aux_x0_no_write got=%h exp=%h", obs, exp);
    end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid_init();
    logic [40:0] obs, exp;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 17; i++) tick();
    @(negedge clk);
    n_cmp++;
    if (rf_a3 !== 5'd17) begin
      n_err++; $display("FAIL sweep_at_17 got=%0d exp=17", rf_a3);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    obs = pk(rf_we, rf_a3, rf_wd3, aux_ready, pipe_stall, init_busy);
    exp = pk(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b1);
    if (obs !== exp) begin
      n_err++; $display("FAIL reset_mid_init got=%h exp=%h", obs, exp);
    end
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_cmp++;
      obs = pk(rf_we, rf_a3, rf_wd3, aux_ready, pipe_stall, init_busy);
      exp = pk(1'b1, 5'(i), 32'd0, 1'b0, 1'b1, 1'b1);
      if (obs !== exp) begin
        n_err++; $display("FAIL sweep_restart[%0d] got=%h exp=%h", i, obs, exp);
      end
      tick();
    end
    for (int i = 2; i < 32; i++) tick();
    @(negedge clk);
    n_cmp++;
    if (init_busy !== 1'b0) begin
      n_err++; $display("FAIL init_done_after_restart got=%b exp=0", init_busy);
    end
  endtask

  task automatic test_no_clear();
    logic [40:0] obs, exp;
    wb_we0 = 1'b1; wb_rd0 = 5'd3; wb_data0 = 32'h33;
    @(negedge clk);
    n_cmp++;
    obs = pk(rf_we0, rf_a30, rf_wd30, aux_ready0, pipe_stall0, init_busy0);
    exp = pk(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    if (obs !== exp) begin
      n_err++; $display("FAIL noclear_reset got=%h exp=%h", obs, exp);
    end
    tick();
    rst0 = 1'b0;
    @(negedge clk);
    n_cmp++;
    obs = pk(rf_we0, rf_a30, rf_wd30, aux_ready0, pipe_stall0, init_busy0);
    exp = pk(1'b1, 5'd3, 32'h33, 1'b0, 1'b0, 1'b0);
    if (obs !== exp) begin
      n_err++; $display("FAIL noclear_first_wb got=%h exp=%h", obs, exp);
    end
    tick();
  endtask

  initial begin
    rst = 1'b1; rst0 = 1'b1;
    idle_inputs();
    wb_we0 = 1'b0; wb_rd0 = '0; wb_data0 = '0;
    test_reset();
    test_wb_priority();
    test_force();
    test_x0();
    test_reset_mid_init();
    test_no_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
